// File: rtl/ahb_mtx_pkg.sv
// Shared AHB matrix definitions: transfer/response encodings and slave-count constants.
package ahb_mtx_pkg;

    localparam int unsigned NUM_SLV = 3;
    localparam int unsigned SEL_W   = NUM_SLV + 1;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned RESP_W  = 2;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    // Data-phase select pointing at the default slave (top bit of the one-hot).
    localparam logic [SEL_W-1:0] DSEL_DEF = {1'b1, {NUM_SLV{1'b0}}};

endpackage

// File: rtl/ahb_mtx_resp_mux.sv
// Data-phase response multiplexer: routes ready/response/read-data of the
// slave selected by the one-hot dsel back to the master.
module ahb_mtx_resp_mux
    import ahb_mtx_pkg::*;
(
    input  logic [SEL_W-1:0]          dsel,
    input  logic [SEL_W-1:0]          hreadyouts,
    input  logic [SEL_W*RESP_W-1:0]   hresps,
    input  logic [NUM_SLV*DATA_W-1:0] hrdatas,
    output logic                      hreadyout_c,
    output logic [RESP_W-1:0]         hresp_c,
    output logic [DATA_W-1:0]         hrdata_c
);

    // One-hot select; anything other than a real slave falls to the default slave.
    always_comb begin
        hreadyout_c = hreadyouts[3];
        hresp_c     = hresps[7:6];
        hrdata_c    = '0;
        case (dsel)
            4'b0001: begin
                hreadyout_c = hreadyouts[0];
                hresp_c     = hresps[1:0];
                hrdata_c    = hrdatas[31:0];
            end
            4'b0010: begin
                hreadyout_c = hreadyouts[1];
                hresp_c     = hresps[3:2];
                hrdata_c    = hrdatas[63:32];
            end
            4'b0100: begin
                hreadyout_c = hreadyouts[2];
                hresp_c     = hresps[5:4];
                hrdata_c    = hrdatas[95:64];
            end
            default: begin
                hreadyout_c = hreadyouts[3];
                hresp_c     = hresps[7:6];
                hrdata_c    = '0;
            end
        endcase
    end

endmodule

// File: rtl/ahb_mtx_slave_decoder.sv
// AHB matrix output-stage slave decoder: address decode to one-hot HSEL,
// registered data-phase select, response mux and unmapped-access capture.
// Optional macro AHB_MTX_DECODER_REMAP_EN adds a REMAP input that moves
// slave 0 to REMAP_BASE while asserted.
module ahb_mtx_slave_decoder
    import ahb_mtx_pkg::*;
#(
    parameter logic [31:0] S0_BASE    = 32'h0000_0000,
    parameter logic [31:0] S0_MASK    = 32'hF000_0000,
    parameter logic [31:0] S1_BASE    = 32'h2000_0000,
    parameter logic [31:0] S1_MASK    = 32'hF000_0000,
    parameter logic [31:0] S2_BASE    = 32'h4000_0000,
    parameter logic [31:0] S2_MASK    = 32'hFFFF_0000
`ifdef AHB_MTX_DECODER_REMAP_EN
    ,
    parameter logic [31:0] REMAP_BASE = 32'h2000_0000
`endif
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
`ifdef AHB_MTX_DECODER_REMAP_EN
    input  logic                      REMAP,
`endif
    input  logic [ADDR_W-1:0]         HADDR,
    input  logic [1:0]                HTRANS,
    input  logic                      HREADY,
    output logic [NUM_SLV-1:0]        HSEL,
    output logic                      HSELDEF,
    input  logic [SEL_W-1:0]          HREADYOUTS,
    input  logic [SEL_W*RESP_W-1:0]   HRESPS,
    input  logic [NUM_SLV*DATA_W-1:0] HRDATAS,
    output logic                      HREADYOUT,
    output logic [RESP_W-1:0]         HRESP,
    output logic [DATA_W-1:0]         HRDATA,
    input  logic                      ERR_CLR,
    output logic                      ERR_VALID,
    output logic [ADDR_W-1:0]         ERR_ADDR
);

    logic [ADDR_W-1:0]  s0_base;
    logic [NUM_SLV-1:0] hit;
    logic [SEL_W-1:0]   dsel;
    logic               htrans_act;
    logic               err_cap;

    // Effective slave 0 base, optionally remapped in the address phase.
    always_comb begin
`ifdef AHB_MTX_DECODER_REMAP_EN
        s0_base = REMAP ? REMAP_BASE : S0_BASE;
`else
        s0_base = S0_BASE;
`endif
    end

    // Per-slave region match.
    always_comb begin
        hit    = '0;
        hit[0] = (HADDR & S0_MASK) == s0_base;
        hit[1] = (HADDR & S1_MASK) == S1_BASE;
        hit[2] = (HADDR & S2_MASK) == S2_BASE;
    end

    // Priority encode to one-hot select; no match goes to the default slave.
    always_comb begin
        HSEL    = '0;
        HSELDEF = 1'b0;
        if (hit[0]) begin
            HSEL = 3'b001;
        end else if (hit[1]) begin
            HSEL = 3'b010;
        end else if (hit[2]) begin
            HSEL = 3'b100;
        end else begin
            HSELDEF = 1'b1;
        end
    end

    // Data-phase select advances only when the bus accepts the address phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel <= DSEL_DEF;
        end else if (HREADY) begin
            dsel <= {HSELDEF, HSEL};
        end
    end

    ahb_mtx_resp_mux u_resp_mux (
        .dsel        (dsel),
        .hreadyouts  (HREADYOUTS),
        .hresps      (HRESPS),
        .hrdatas     (HRDATAS),
        .hreadyout_c (HREADYOUT),
        .hresp_c     (HRESP),
        .hrdata_c    (HRDATA)
    );

    // Active transfer and capture qualifier; a clear in the same cycle lets a new capture win.
    always_comb begin
        htrans_act = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
        err_cap    = HREADY && HSELDEF && htrans_act && (!ERR_VALID || ERR_CLR);
    end

    // Sticky capture of the first unmapped access address.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ERR_VALID <= 1'b0;
            ERR_ADDR  <= '0;
        end else if (err_cap) begin
            ERR_VALID <= 1'b1;
            ERR_ADDR  <= HADDR;
        end else if (ERR_CLR) begin
            ERR_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ahb_mtx_slave_decoder.sv
// Directed bench for ahb_mtx_slave_decoder. S1 is widened to 0x0000_0000/0xC000_0000
// so that S0 and S1 overlap at low addresses and decode priority is observable.
module tb_ahb_mtx_slave_decoder;

    typedef enum int {
        SIG_HSEL, SIG_HSELDEF, SIG_HREADYOUT, SIG_HRESP, SIG_HRDATA, SIG_ERR_VALID, SIG_ERR_ADDR
    } sig_e;

    typedef struct {
        string       tag;
        sig_e        sig;
        logic [31:0] exp;
    } exp_t;

    localparam logic [31:0] D0 = 32'hA5A5_0000;
    localparam logic [31:0] D1 = 32'hA5A5_0001;
    localparam logic [31:0] D2 = 32'hA5A5_0002;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        remap;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HREADY;
    logic [2:0]  HSEL;
    logic        HSELDEF;
    logic [3:0]  HREADYOUTS;
    logic [7:0]  HRESPS;
    logic [95:0] HRDATAS;
    logic        HREADYOUT;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;
    logic        ERR_CLR;
    logic        ERR_VALID;
    logic [31:0] ERR_ADDR;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 HCLK = ~HCLK;

    ahb_mtx_slave_decoder #(
        .S1_BASE (32'h0000_0000),
        .S1_MASK (32'hC000_0000)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
`ifdef AHB_MTX_DECODER_REMAP_EN
        .REMAP      (remap),
`endif
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HREADY     (HREADY),
        .HSEL       (HSEL),
        .HSELDEF    (HSELDEF),
        .HREADYOUTS (HREADYOUTS),
        .HRESPS     (HRESPS),
        .HRDATAS    (HRDATAS),
        .HREADYOUT  (HREADYOUT),
        .HRESP      (HRESP),
        .HRDATA     (HRDATA),
        .ERR_CLR    (ERR_CLR),
        .ERR_VALID  (ERR_VALID),
        .ERR_ADDR   (ERR_ADDR)
    );

    function automatic logic [31:0] observe(input sig_e s);
        case (s)
            SIG_HSEL:      return 32'(HSEL);
            SIG_HSELDEF:   return 32'(HSELDEF);
            SIG_HREADYOUT: return 32'(HREADYOUT);
            SIG_HRESP:     return 32'(HRESP);
            SIG_HRDATA:    return HRDATA;
            SIG_ERR_VALID: return 32'(ERR_VALID);
            default:       return ERR_ADDR;
        endcase
    endfunction

    task automatic expect_sig(input sig_e s, input logic [31:0] v, input string tag);
        exp_t e;
        e.tag = tag;
        e.sig = s;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.sig);
            n_vec++;
            assert (o === e.exp) else begin
                n_err++;
                $error("FAIL %s: observed 0x%08h expected 0x%08h", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic r);
        HADDR  = a;
        HTRANS = t;
        HREADY = r;
    endtask

    initial begin
        HRESETn    = 1'b0;
        remap      = 1'b0;
        ERR_CLR    = 1'b0;
        HREADYOUTS = 4'hF;
        HRESPS     = 8'h00;
        HRDATAS    = {D2, D1, D0};
        drive(32'h0, 2'b00, 1'b1);

        // Reset state
        @(negedge HCLK);
        #1;
        expect_sig(SIG_HREADYOUT, 32'h1, "rst_hreadyout");
        expect_sig(SIG_HRESP,     32'h0, "rst_hresp");
        expect_sig(SIG_HRDATA,    32'h0, "rst_hrdata");
        expect_sig(SIG_ERR_VALID, 32'h0, "rst_err_valid");
        expect_sig(SIG_ERR_ADDR,  32'h0, "rst_err_addr");
        check_all();
        HRESETn = 1'b1;

        // NONSEQ to slave 1
        @(negedge HCLK);
        drive(32'h2000_0010, 2'b10, 1'b1);
        #1;
        expect_sig(SIG_HSEL,    32'h2, "s1_hsel");
        expect_sig(SIG_HSELDEF, 32'h0, "s1_hseldef");
        check_all();

        // Slave 1 data phase stalls two cycles while slave 2 address is presented
        @(negedge HCLK);
        drive(32'h4000_0000, 2'b10, 1'b0);
        HREADYOUTS = 4'b1101;
        #1;
        expect_sig(SIG_HRDATA,    D1,    "s1_hrdata");
        expect_sig(SIG_HRESP,     32'h0, "s1_hresp");
        expect_sig(SIG_HREADYOUT, 32'h0, "s1_wait1");
        expect_sig(SIG_HSEL,      32'h4, "s2_hsel");
        check_all();

        @(negedge HCLK);
        #1;
        expect_sig(SIG_HREADYOUT, 32'h0, "s1_wait2");
        expect_sig(SIG_HRDATA,    D1,    "s1_hold_data");
        check_all();

        @(negedge HCLK);
        HREADYOUTS = 4'hF;
        HREADY     = 1'b1;
        #1;
        expect_sig(SIG_HREADYOUT, 32'h1, "s1_done");
        expect_sig(SIG_HRDATA,    D1,    "s1_done_data");
        check_all();

        // Slave 2 data phase; NONSEQ to unmapped address
        @(negedge HCLK);
        drive(32'h8000_0004, 2'b10, 1'b1);
        #1;
        expect_sig(SIG_HRDATA,    D2,    "s2_hrdata");
        expect_sig(SIG_HREADYOUT, 32'h1, "s2_hreadyout");
        expect_sig(SIG_HSEL,      32'h0, "def_hsel");
        expect_sig(SIG_HSELDEF,   32'h1, "def_hseldef");
        expect_sig(SIG_ERR_VALID, 32'h0, "err_pre_cap");
        check_all();

        // Default slave two-cycle ERROR passes through
        @(negedge HCLK);
        drive(32'h0, 2'b00, 1'b0);
        HREADYOUTS = 4'b0111;
        HRESPS     = 8'b01_00_00_00;
        #1;
        expect_sig(SIG_HREADYOUT, 32'h0,         "err_c1_ready");
        expect_sig(SIG_HRESP,     32'h1,         "err_c1_resp");
        expect_sig(SIG_HRDATA,    32'h0,         "def_hrdata");
        expect_sig(SIG_ERR_VALID, 32'h1,         "err_valid");
        expect_sig(SIG_ERR_ADDR,  32'h8000_0004, "err_addr");
        expect_sig(SIG_HSEL,      32'h1,         "overlap_hsel");
        check_all();

        @(negedge HCLK);
        HREADYOUTS = 4'hF;
        HREADY     = 1'b1;
        #1;
        expect_sig(SIG_HREADYOUT, 32'h1, "err_c2_ready");
        expect_sig(SIG_HRESP,     32'h1, "err_c2_resp");
        check_all();

        // Second unmapped access while capture is held
        @(negedge HCLK);
        HRESPS = 8'h00;
        drive(32'h9000_0000, 2'b10, 1'b1);
        #1;
        expect_sig(SIG_HSELDEF, 32'h1, "def2_hseldef");
        expect_sig(SIG_HRDATA,  D0,    "s0_hrdata");
        expect_sig(SIG_HRESP,   32'h0, "s0_hresp");
        check_all();

        // ERR_CLR together with a third unmapped NONSEQ
        @(negedge HCLK);
        drive(32'hA000_0000, 2'b10, 1'b1);
        ERR_CLR = 1'b1;
        #1;
        expect_sig(SIG_ERR_ADDR,  32'h8000_0004, "err_sticky_addr");
        expect_sig(SIG_ERR_VALID, 32'h1,         "err_sticky_valid");
        check_all();

        // ERR_CLR alone on an IDLE cycle
        @(negedge HCLK);
        drive(32'h0, 2'b00, 1'b1);
        #1;
        expect_sig(SIG_ERR_VALID, 32'h1,         "clr_cap_valid");
        expect_sig(SIG_ERR_ADDR,  32'hA000_0000, "clr_cap_addr");
        check_all();

        // BUSY to unmapped: no capture
        @(negedge HCLK);
        ERR_CLR = 1'b0;
        drive(32'hB000_0000, 2'b01, 1'b1);
        #1;
        expect_sig(SIG_ERR_VALID, 32'h0,         "clr_valid");
        expect_sig(SIG_ERR_ADDR,  32'hA000_0000, "clr_keeps_addr");
        expect_sig(SIG_HSELDEF,   32'h1,         "busy_hseldef");
        check_all();

        // NONSEQ to unmapped with HREADY low: no capture
        @(negedge HCLK);
        drive(32'hC000_0000, 2'b10, 1'b0);
        #1;
        expect_sig(SIG_ERR_VALID, 32'h0, "busy_no_cap");
        check_all();

        // Top of slave 2 region
        @(negedge HCLK);
        drive(32'h4000_FFFC, 2'b11, 1'b1);
        #1;
        expect_sig(SIG_ERR_VALID, 32'h0, "nrdy_no_cap");
        expect_sig(SIG_HSEL,      32'h4, "s2_top_hsel");
        check_all();

        // Just past slave 2 region
        @(negedge HCLK);
        drive(32'h4001_0000, 2'b00, 1'b1);
        #1;
        expect_sig(SIG_HSELDEF, 32'h1, "s2_past_hseldef");
        expect_sig(SIG_HSEL,    32'h0, "s2_past_hsel");
        expect_sig(SIG_HRDATA,  D2,    "s2_top_hrdata");
        check_all();

        // 0x2000_0000 decodes to S1 normally, to S0 under REMAP
        @(negedge HCLK);
        drive(32'h2000_0000, 2'b00, 1'b1);
`ifdef AHB_MTX_DECODER_REMAP_EN
        remap = 1'b1;
        #1;
        expect_sig(SIG_HSEL, 32'h1, "remap_hsel");
`else
        #1;
        expect_sig(SIG_HSEL, 32'h2, "noremap_hsel");
`endif
        check_all();
        remap = 1'b0;

        // Set up a capture, then reset mid slave 2 data phase
        @(negedge HCLK);
        drive(32'h8000_0000, 2'b10, 1'b1);
        #1;
        expect_sig(SIG_HSELDEF, 32'h1, "def3_hseldef");
        check_all();

        @(negedge HCLK);
        drive(32'h4000_0000, 2'b10, 1'b1);
        #1;
        expect_sig(SIG_ERR_VALID, 32'h1,         "pre_rst_valid");
        expect_sig(SIG_ERR_ADDR,  32'h8000_0000, "pre_rst_addr");
        check_all();

        @(negedge HCLK);
        drive(32'h0, 2'b00, 1'b0);
        HREADYOUTS = 4'b1011;
        #1;
        expect_sig(SIG_HREADYOUT, 32'h0, "s2_stall");
        expect_sig(SIG_HRDATA,    D2,    "s2_stall_data");
        check_all();
        #1;
        HRESETn = 1'b0;
        #1;
        expect_sig(SIG_HREADYOUT, 32'h1, "mid_rst_hreadyout");
        expect_sig(SIG_HRESP,     32'h0, "mid_rst_hresp");
        expect_sig(SIG_HRDATA,    32'h0, "mid_rst_hrdata");
        expect_sig(SIG_ERR_VALID, 32'h0, "mid_rst_err_valid");
        expect_sig(SIG_ERR_ADDR,  32'h0, "mid_rst_err_addr");
        check_all();

        @(negedge HCLK);
        HRESETn    = 1'b1;
        HREADYOUTS = 4'hF;
        @(negedge HCLK);
        #1;
        expect_sig(SIG_HRDATA,    32'h0, "post_rst_hrdata");
        expect_sig(SIG_HREADYOUT, 32'h1, "post_rst_hreadyout");
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ahb_mtx_slave_decoder.md
Name: ahb_mtx_slave_decoder

Overview:
- Address decoder and response multiplexer for one matrix output stage.
- Decodes the master address phase into one-hot HSEL for three real slaves plus the default slave.
- Registers the data-phase select and routes HREADYOUT/HRESP/HRDATA from the selected slave back to the master.
- Captures the address of the first unmapped (default-slave) access for debug.

Parameters:
- S0_BASE, 32'h0000_0000, slave 0 base address (compared under S0_MASK)
- S0_MASK, 32'hF000_0000, slave 0 decode mask
- S1_BASE, 32'h2000_0000, slave 1 base address
- S1_MASK, 32'hF000_0000, slave 1 decode mask
- S2_BASE, 32'h4000_0000, slave 2 base address
- S2_MASK, 32'hFFFF_0000, slave 2 decode mask
- REMAP_BASE, 32'h2000_0000, slave 0 base address used while REMAP=1 (feature only)

Ports:
- HCLK  in  1  AHB clock
- HRESETn  in  1  asynchronous active-low reset
- HADDR  in  32  address-phase address
- HTRANS  in  2  transfer type
- HREADY  in  1  bus-level HREADY (also fed to all slaves)
- HSEL  out  3  one-hot address-phase select, slaves 0..2
- HSELDEF  out  1  default-slave select
- HREADYOUTS  in  4  slave HREADYOUT; bit 3 = default slave
- HRESPS  in  8  slave HRESP, 2 bits per slave; [7:6] = default slave
- HRDATAS  in  96  slave HRDATA, 32 bits per slave, slaves 0..2
- HREADYOUT  out  1  muxed ready to master
- HRESP  out  2  muxed response (00 OKAY, 01 ERROR)
- HRDATA  out  32  muxed read data
- ERR_CLR  in  1  clears the error-capture register
- ERR_VALID  out  1  sticky: unmapped access captured
- ERR_ADDR  out  32  address of the first unmapped access

Behaviour:
- Clock is HCLK. Reset is HRESETn, asynchronous, active-low.
- Address decode (combinational):
  - slave i matches when (HADDR & Si_MASK) == Si_BASE.
  - Priority 0 > 1 > 2; exactly one HSEL bit high on a match.
  - No match -> HSELDEF=1, HSEL=0.
  - HSEL/HSELDEF do not depend on HTRANS or HREADY; slaves qualify them with those signals.
- Data-phase select dsel (4-bit one-hot register):
  - Reset value 4'b1000 (default slave).
  - When HREADY=1: dsel <= {HSELDEF, HSEL}. When HREADY=0: dsel holds.
- Response mux (combinational from dsel):
  - HREADYOUT = HREADYOUTS[k], HRESP = HRESPS[2k+1:2k], where k is the dsel index.
  - HRDATA = HRDATAS slice for slaves 0..2; 32'h0 when dsel selects the default slave.
- Reset values: dsel = default slave, so HREADYOUT follows default slave (1) and HRESP follows default slave (00).
  - ERR_VALID = 0, ERR_ADDR = 0.
- Latency: address phase in cycle N; cycle N+1 output mux uses the slave selected in cycle N. No added wait states.
- Wait states: while HREADY=0, dsel is frozen and a new address-phase decode does not disturb the data-phase mux.
- ERROR handling:
  - Two-cycle ERROR responses (cycle 1 HREADYOUT=0/HRESP=01, cycle 2 HREADYOUT=1/HRESP=01) pass through unchanged.
  - The decoder never generates responses itself.
- Error capture:
  - Capture condition: HREADY & HSELDEF & HTRANS[1] & ~ERR_VALID.
  - On capture: ERR_ADDR <= HADDR, ERR_VALID <= 1.
  - First error is sticky; later unmapped accesses are ignored until cleared.
  - ERR_CLR=1 alone clears ERR_VALID; ERR_ADDR is retained.
  - ERR_CLR together with the capture condition (evaluated with ERR_VALID treated as 0): capture wins; ERR_VALID=1 and ERR_ADDR = new address.
  - IDLE/BUSY to unmapped addresses: no capture.
- Reset mid-transfer: all registers return to reset values immediately; the outstanding data phase is abandoned.

Optional Feature:
- Macro: AHB_MTX_DECODER_REMAP_EN.
- Defined:
  - Extra input REMAP (1 bit).
  - While REMAP=1, slave 0 decodes with REMAP_BASE/S0_MASK and keeps its priority over slave 1.
  - REMAP is sampled combinationally in the address phase.
- Undefined:
  - No REMAP port.
  - Slave 0 always uses S0_BASE.

Decomposition:
- Shared package `ahb_mtx_pkg`:
  - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ).
  - HRESP encodings (OKAY/ERROR/RETRY/SPLIT).
  - Slave-count constant NUM_SLV=3.
- One natural sub-module, ahb_mtx_resp_mux: the dsel-indexed HREADYOUT/HRESP/HRDATA mux.
- Decode and error capture stay in the top module.

Test Plan:
- NONSEQ read at 0x2000_0010, HREADY=1:
  - address phase: HSEL=3'b010.
  - next cycle: HRDATA = slave1 data 0xA5A5_0001, HRESP=00.
- Slave 1 holds HREADYOUTS[1]=0 for 2 cycles while the next address 0x4000_0000 is presented:
  - HREADYOUT=0 for 2 cycles.
  - dsel stays slave 1 throughout.
  - slave 2 is selected in the data phase only after HREADY rises.
- NONSEQ to unmapped 0x8000_0004:
  - HSELDEF=1.
  - default slave's 2-cycle ERROR passes through (HREADYOUT 0 then 1, HRESP=01).
  - ERR_VALID=1, ERR_ADDR=0x8000_0004.
- Second unmapped access to 0x9000_0000 while ERR_VALID=1:
  - ERR_ADDR stays 0x8000_0004.
  - ERR_CLR pulsed in the same cycle as a third unmapped NONSEQ to 0xA000_0000 -> ERR_VALID=1, ERR_ADDR=0xA000_0000.
- Overlapping decode, HADDR=0x0000_0000 with S0 and a widened S1 region both matching:
  - HSEL=3'b001 (priority).
  - with AHB_MTX_DECODER_REMAP_EN defined and REMAP=1, HADDR=0x2000_0000 -> HSEL=3'b001.
- HRESETn asserted mid data phase of a slave 2 transfer:
  - HREADYOUT immediately follows HREADYOUTS[3].
  - ERR_VALID=0.
